// File: rtl/ssd_mux.sv
// Eight-digit multiplexed seven-segment driver; input data is latched once per frame.
// Define SSD_MUX_BLANK_EN to enable leading-zero blanking of digits 1..7.
module ssd_mux #(
    parameter int DIV = 100000
) (
    input  logic        ssd_mux_port_clk,
    input  logic        ssd_mux_port_rst,
    input  logic        ssd_mux_port_en,
    input  logic [31:0] ssd_mux_port_data,
    input  logic [7:0]  ssd_mux_port_dp,
    output logic [6:0]  ssd_mux_port_ssd,
    output logic        ssd_mux_port_odp,
    output logic [7:0]  ssd_mux_port_an,
    output logic        ssd_mux_port_tick
);

    localparam int            CW         = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] PRESC_LAST = CW'(DIV - 1);

    logic [CW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   shData_q, shData_d;
    logic [7:0]    shDp_q, shDp_d;
    logic          tick_q, tick_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    ssd_q, ssd_d;
    logic          odp_q, odp_d;
    logic [3:0]    nibble;

    function automatic logic [6:0] hexGlyph(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Shadow registers only refresh on the 7->0 wrap so one frame never mixes two inputs.
    always_comb begin
        presc_d  = presc_q;
        idx_d    = idx_q;
        shData_d = shData_q;
        shDp_d   = shDp_q;
        tick_d   = 1'b0;
        if (ssd_mux_port_en) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = idx_q + 3'd1;
                tick_d  = 1'b1;
                if (idx_q == 3'd7) begin
                    shData_d = ssd_mux_port_data;
                    shDp_d   = ssd_mux_port_dp;
                end
            end else begin
                presc_d = presc_q + CW'(1);
            end
        end
    end

    always_comb begin
        nibble = shData_q[{idx_q, 2'b00} +: 4];
        an_d   = ~(8'd1 << idx_q);
        ssd_d  = hexGlyph(nibble);
        odp_d  = ~shDp_q[idx_q];
`ifdef SSD_MUX_BLANK_EN
        // A digit is blank when it and every more-significant nibble are zero.
        if ((idx_q != 3'd0) && ((shData_q >> {idx_q, 2'b00}) == 32'd0)) begin
            ssd_d = 7'h7F;
        end
`endif
    end

    always_ff @(posedge ssd_mux_port_clk or negedge ssd_mux_port_rst) begin
        if (!ssd_mux_port_rst) begin
            presc_q  <= '0;
            idx_q    <= 3'd0;
            shData_q <= 32'd0;
            shDp_q   <= 8'd0;
            tick_q   <= 1'b0;
            an_q     <= 8'hFF;
            ssd_q    <= 7'h7F;
            odp_q    <= 1'b1;
        end else begin
            presc_q  <= presc_d;
            idx_q    <= idx_d;
            shData_q <= shData_d;
            shDp_q   <= shDp_d;
            tick_q   <= tick_d;
            an_q     <= an_d;
            ssd_q    <= ssd_d;
            odp_q    <= odp_d;
        end
    end

    assign ssd_mux_port_ssd  = ssd_q;
    assign ssd_mux_port_odp  = odp_q;
    assign ssd_mux_port_an   = an_q;
    assign ssd_mux_port_tick = tick_q;

endmodule
